// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: op encodings, FSM states, datapath width.
package mem_access_stage_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        MA_OP_NONE  = 2'b00,
        MA_OP_LOAD  = 2'b01,
        MA_OP_STORE = 2'b10,
        MA_OP_RSVD  = 2'b11
    } ma_op_e;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_WAIT = 1'b1
    } ma_state_e;

    function automatic logic is_mem_op(input ma_op_e op);
        return (op == MA_OP_LOAD) || (op == MA_OP_STORE);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MA stage, as seen from the stage (master) and the memory (slave).
interface mem_access_stage_if
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
);
    // Handshake: MEM_REQ rises with MEM_WE/MEM_ADDR/MEM_WDATA and all four stay stable
    // until MEM_ACK is sampled high; MEM_RDATA is only meaningful in that ACK cycle.
    logic             MEM_REQ;
    logic             MEM_WE;
    logic [WIDTH-1:0] MEM_ADDR;
    logic [WIDTH-1:0] MEM_WDATA;
    logic [WIDTH-1:0] MEM_RDATA;
    logic             MEM_ACK;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_RDATA, MEM_ACK
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_RDATA, MEM_ACK
    );

endinterface

// File: rtl/ma_watchdog.sv
// Wait counter for outstanding memory requests; exists only when MA_TIMEOUT_EN is defined.
`ifdef MA_TIMEOUT_EN
module ma_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic active,
    input  logic ack,
    output logic expired
);

    logic [7:0] cnt;

    // Held at zero outside WAIT so every new transaction starts counting from 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= 8'd0;
        end else if (!active) begin
            cnt <= 8'd0;
        end else if (!ack) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = active && !ack && (cnt == 8'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mem_access_stage.sv
// MA pipeline stage: ALU results pass through, loads/stores run a req/ack memory transaction.
// Define MA_TIMEOUT_EN to abort transactions that wait TIMEOUT cycles without MEM_ACK.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WORD_WIDTH = mem_access_stage_pkg::WORD_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  In_Valid,
    input  logic [1:0]            In_Op,
    input  logic [WORD_WIDTH-1:0] C_In,
    input  logic [WORD_WIDTH-1:0] B_In,
    input  logic [4:0]            Addr_In,
    output logic                  STALL,
    mem_access_stage_if.master    mem,
    output logic [WORD_WIDTH-1:0] C_1,
    output logic [4:0]            Addr_1,
    output logic                  Valid_1,
    output logic                  ERR,
    output ma_state_e             Dbg_State
);

    ma_state_e             state, state_nx;
    logic                  req_q, req_nx;
    logic                  we_q, we_nx;
    logic [WORD_WIDTH-1:0] addr_q, addr_nx;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_nx;
    logic [WORD_WIDTH-1:0] c1_q, c1_nx;
    logic [4:0]            a1_q, a1_nx;
    logic                  v1_q, v1_nx;
    logic                  err_q, err_nx;
    logic [4:0]            dest_q, dest_nx;
    logic                  isload_q, isload_nx;
    logic                  wd_expired;
    ma_op_e                op;

    assign op = ma_op_e'(In_Op);

`ifdef MA_TIMEOUT_EN
    ma_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .active  (state == MA_WAIT),
        .ack     (mem.MEM_ACK),
        .expired (wd_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 255);
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= MA_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_nx    = req_q;
        we_nx     = we_q;
        addr_nx   = addr_q;
        wdata_nx  = wdata_q;
        c1_nx     = c1_q;
        a1_nx     = a1_q;
        v1_nx     = 1'b0;
        err_nx    = 1'b0;
        dest_nx   = dest_q;
        isload_nx = isload_q;
        case (state)
            MA_IDLE: begin
                if (!In_Valid) begin
                    a1_nx = 5'd0;
                end else if (is_mem_op(op)) begin
                    req_nx    = 1'b1;
                    we_nx     = (op == MA_OP_STORE);
                    addr_nx   = C_In;
                    wdata_nx  = B_In;
                    dest_nx   = Addr_In;
                    isload_nx = (op == MA_OP_LOAD);
                    a1_nx     = 5'd0;
                    state_nx  = MA_WAIT;
                end else begin
                    c1_nx = C_In;
                    a1_nx = Addr_In;
                    v1_nx = 1'b1;
                end
            end
            MA_WAIT: begin
                // ACK takes priority over a coincident timeout.
                if (mem.MEM_ACK) begin
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    v1_nx    = 1'b1;
                    state_nx = MA_IDLE;
                    if (isload_q) begin
                        c1_nx = mem.MEM_RDATA;
                        a1_nx = dest_q;
                    end else begin
                        a1_nx = 5'd0;
                    end
                end else if (wd_expired) begin
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    v1_nx    = 1'b1;
                    a1_nx    = 5'd0;
                    err_nx   = 1'b1;
                    state_nx = MA_IDLE;
                end
            end
            default: state_nx = MA_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            c1_q     <= '0;
            a1_q     <= 5'd0;
            v1_q     <= 1'b0;
            err_q    <= 1'b0;
            dest_q   <= 5'd0;
            isload_q <= 1'b0;
        end else begin
            req_q    <= req_nx;
            we_q     <= we_nx;
            addr_q   <= addr_nx;
            wdata_q  <= wdata_nx;
            c1_q     <= c1_nx;
            a1_q     <= a1_nx;
            v1_q     <= v1_nx;
            err_q    <= err_nx;
            dest_q   <= dest_nx;
            isload_q <= isload_nx;
        end
    end

    assign STALL         = (state == MA_WAIT);
    assign mem.MEM_REQ   = req_q;
    assign mem.MEM_WE    = we_q;
    assign mem.MEM_ADDR  = addr_q;
    assign mem.MEM_WDATA = wdata_q;
    assign C_1           = c1_q;
    assign Addr_1        = a1_q;
    assign Valid_1       = v1_q;
    assign ERR           = err_q;
    assign Dbg_State     = state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vectors, multi-cycle corner sequences, randomized run.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         In_Valid;
    logic [1:0]   In_Op;
    logic [W-1:0] C_In, B_In;
    logic [4:0]   Addr_In;
    logic         STALL, Valid_1, ERR;
    logic [W-1:0] C_1;
    logic [4:0]   Addr_1;
    ma_state_e    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage_if #(.WIDTH(W)) mif ();

    mem_access_stage #(.WORD_WIDTH(W), .TIMEOUT(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .In_Valid  (In_Valid),
        .In_Op     (In_Op),
        .C_In      (C_In),
        .B_In      (B_In),
        .Addr_In   (Addr_In),
        .STALL     (STALL),
        .mem       (mif),
        .C_1       (C_1),
        .Addr_1    (Addr_1),
        .Valid_1   (Valid_1),
        .ERR       (ERR),
        .Dbg_State (dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- driver / check helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] c,
                         input logic [W-1:0] b, input logic [4:0] a);
        In_Valid = v;
        In_Op    = op;
        C_In     = c;
        B_In     = b;
        Addr_In  = a;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] model_mem[logic [W-1:0]];
    logic [W-1:0] resp_mem[logic [W-1:0]];
    logic [W+4:0] exp_q[$];
    logic [2*W:0] req_q[$];
    logic [W-1:0] last_c1;

    function automatic logic [W-1:0] init_val(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3C3_0000;
    endfunction

    // Architectural effect of one accepted instruction, in program order.
    task automatic model_issue(input logic [1:0] op, input logic [W-1:0] c,
                               input logic [W-1:0] b, input logic [4:0] a);
        logic [W-1:0] v;
        if (op == 2'b01) begin
            v = model_mem.exists(c) ? model_mem[c] : init_val(c);
            exp_q.push_back({v, a});
            req_q.push_back({1'b0, c, b});
            last_c1 = v;
        end else if (op == 2'b10) begin
            model_mem[c] = b;
            exp_q.push_back({last_c1, 5'd0});
            req_q.push_back({1'b1, c, b});
        end else begin
            exp_q.push_back({c, a});
            last_c1 = c;
        end
    endtask

    typedef struct {
        logic         v;
        logic [1:0]   op;
        logic [W-1:0] c;
        logic [4:0]   a;
        logic         ack;
        logic         ev;
        logic [W-1:0] ec;
        logic [4:0]   ea;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit           stall_prev;
        bit           busy;
        bit           ack_drv;
        int           dly;
        logic [2*W:0] rq;
        logic [W+4:0] ex;

        tbl[0] = '{1'b1, 2'b00, 32'h11, 5'd5, 1'b0, 1'b1, 32'h11, 5'd5};
        tbl[1] = '{1'b1, 2'b00, 32'h22, 5'd6, 1'b0, 1'b1, 32'h22, 5'd6};
        tbl[2] = '{1'b1, 2'b00, 32'h33, 5'd7, 1'b0, 1'b1, 32'h33, 5'd7};
        tbl[3] = '{1'b0, 2'b01, 32'h99, 5'd9, 1'b1, 1'b0, 32'h33, 5'd0};
        tbl[4] = '{1'b1, 2'b11, 32'h44, 5'd8, 1'b0, 1'b1, 32'h44, 5'd8};
        tbl[5] = '{1'b1, 2'b00, 32'h55, 5'd0, 1'b1, 1'b1, 32'h55, 5'd0};
        tbl[6] = '{1'b0, 2'b00, 32'h66, 5'd3, 1'b0, 1'b0, 32'h55, 5'd0};
        tbl[7] = '{1'b1, 2'b00, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'd31};

        // ---------------- reset ----------------
        RST_N = 1'b0;
        mif.MEM_ACK   = 1'b0;
        mif.MEM_RDATA = 32'h1234_5678;
        drive(1'b1, 2'b01, 32'h80, 32'h81, 5'd2);
        #1;
        for (int i = 0; i < 4; i++) begin
            mif.MEM_ACK = ~mif.MEM_ACK;
            step();
            chk("reset_outputs",
                {Valid_1, STALL, ERR, mif.MEM_REQ, mif.MEM_WE, Addr_1, C_1, mif.MEM_ADDR, mif.MEM_WDATA},
                '0);
        end
        mif.MEM_ACK = 1'b0;
        RST_N = 1'b1;
        drive(1'b1, 2'b00, 32'hA5, 32'h0, 5'd1);
        step();
        chk("first_after_reset", {Valid_1, STALL, Addr_1, C_1}, {1'b1, 1'b0, 5'd1, 32'hA5});

        // ---------------- table-driven single-cycle vectors ----------------
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].c, 32'h0, tbl[i].a);
            mif.MEM_ACK = tbl[i].ack;
            step();
            chk($sformatf("vec%0d", i), {Valid_1, STALL, mif.MEM_REQ, Addr_1, C_1},
                {tbl[i].ev, 1'b0, 1'b0, tbl[i].ea, tbl[i].ec});
        end
        mif.MEM_ACK = 1'b0;

        // ---------------- load with three extra wait cycles ----------------
        drive(1'b1, 2'b01, 32'h100, 32'h0, 5'd9);
        step();
        drive(1'b1, 2'b00, 32'h77, 32'h0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mif.MEM_ACK   = 1'b1;
                mif.MEM_RDATA = 32'hDEAD_BEEF;
            end
            chk($sformatf("load_wait%0d", i), {STALL, Valid_1, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR},
                {1'b1, 1'b0, 1'b1, 1'b0, 32'h100});
            step();
        end
        mif.MEM_ACK = 1'b0;
        chk("load_retire", {Valid_1, STALL, mif.MEM_REQ, Addr_1, C_1},
            {1'b1, 1'b0, 1'b0, 5'd9, 32'hDEAD_BEEF});
        step();
        chk("none_after_load", {Valid_1, Addr_1, C_1}, {1'b1, 5'd3, 32'h77});

        // ---------------- store with immediate ACK, NONE held behind ----------------
        drive(1'b1, 2'b10, 32'h40, 32'hCAFE, 5'd12);
        step();
        chk("store_req", {STALL, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA},
            {1'b1, 1'b1, 1'b1, 32'h40, 32'hCAFE});
        drive(1'b1, 2'b00, 32'h88, 32'h0, 5'd4);
        mif.MEM_ACK = 1'b1;
        step();
        mif.MEM_ACK = 1'b0;
        chk("store_retire", {Valid_1, STALL, mif.MEM_REQ, mif.MEM_WE, Addr_1, C_1},
            {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h77});
        step();
        chk("none_after_store", {Valid_1, Addr_1, C_1}, {1'b1, 5'd4, 32'h88});

        // ---------------- reset in the middle of a load ----------------
        drive(1'b1, 2'b01, 32'h200, 32'h0, 5'd10);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("midreset_req_up", {mif.MEM_REQ, STALL}, 2'b11);
        #2 RST_N = 1'b0;
        #1;
        chk("midreset_async_drop", {mif.MEM_REQ, STALL, dbg_state}, {1'b0, 1'b0, MA_IDLE});
        mif.MEM_ACK   = 1'b1;
        mif.MEM_RDATA = 32'hBAD0_BAD0;
        step();
        RST_N = 1'b1;
        step();
        chk("late_ack_ignored", {Valid_1, STALL, mif.MEM_REQ, Addr_1, C_1}, '0);
        mif.MEM_ACK = 1'b0;

`ifdef MA_TIMEOUT_EN
        // ---------------- timeout, TIMEOUT=4 ----------------
        drive(1'b1, 2'b01, 32'h300, 32'h0, 5'd11);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("to_wait%0d", i), {STALL, ERR, Valid_1}, 3'b100);
            step();
        end
        step();
        chk("to_expire", {ERR, Valid_1, Addr_1, STALL, mif.MEM_REQ, dbg_state},
            {1'b1, 1'b1, 5'd0, 1'b0, 1'b0, MA_IDLE});
        step();
        chk("to_err_pulse", {ERR, Valid_1}, 2'b00);
        drive(1'b1, 2'b01, 32'h304, 32'h0, 5'd12);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 3; i++) step();
        mif.MEM_ACK   = 1'b1;
        mif.MEM_RDATA = 32'h1234;
        step();
        mif.MEM_ACK = 1'b0;
        chk("to_ack_wins", {ERR, Valid_1, Addr_1, C_1}, {1'b0, 1'b1, 5'd12, 32'h1234});
`endif

        // ---------------- randomized run against the model ----------------
        RST_N = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        step();
        RST_N = 1'b1;
        last_c1    = '0;
        stall_prev = 1'b0;
        busy       = 1'b0;
        ack_drv    = 1'b0;
        dly        = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            step();
            if (!stall_prev && In_Valid) model_issue(In_Op, C_In, B_In, Addr_In);

            if (Valid_1) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_retire", {Valid_1}, 1'b0);
                end else begin
                    ex = exp_q.pop_front();
                    chk("rand_retire", {C_1, Addr_1}, ex);
                end
            end

            if (ack_drv) begin
                ack_drv     = 1'b0;
                busy        = 1'b0;
                mif.MEM_ACK = 1'b0;
            end else begin
                if (mif.MEM_REQ && !busy) begin
                    if (req_q.size() == 0) begin
                        chk("rand_unexpected_req", {mif.MEM_REQ}, 1'b0);
                    end else begin
                        rq = req_q.pop_front();
                        chk("rand_req", {mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA}, rq);
                    end
                    busy = 1'b1;
                    dly  = $urandom_range(0, 3);
                end
                if (busy) begin
                    if (dly == 0) begin
                        ack_drv       = 1'b1;
                        mif.MEM_ACK   = 1'b1;
                        mif.MEM_RDATA = resp_mem.exists(mif.MEM_ADDR) ? resp_mem[mif.MEM_ADDR]
                                                                      : init_val(mif.MEM_ADDR);
                        if (mif.MEM_WE) resp_mem[mif.MEM_ADDR] = mif.MEM_WDATA;
                    end else begin
                        dly--;
                    end
                end
            end

            if (!stall_prev) begin
                if (cyc < 380 && $urandom_range(0, 4) != 0) begin
                    In_Op    = 2'($urandom_range(0, 3));
                    C_In     = (In_Op == 2'b01 || In_Op == 2'b10) ? {27'd0, 3'($urandom_range(0, 7)), 2'b00}
                                                                  : $urandom;
                    B_In     = $urandom;
                    Addr_In  = 5'($urandom_range(0, 31));
                    In_Valid = 1'b1;
                end else begin
                    In_Valid = 1'b0;
                end
            end
            stall_prev = STALL;
        end
        chk("rand_drain_retire", 32'(exp_q.size()), 32'd0);
        chk("rand_drain_req", 32'(req_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
